// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bundle: ID/EX/MEM hazard inputs
// and pipeline register enable/flush controls.
interface hazard_stall_unit_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       ID_opcode;
   logic [4:0]       ID_ReadRegNum1;
   logic [4:0]       ID_ReadRegNum2;
   logic             EX_cntl_MemRead;
   logic [4:0]       EX_WriteRegNum;
   logic             EX_BranchTaken;
   logic             MEM_cntl_MemRead;
   logic             MEM_cntl_MemWrite;
   logic             dmem_ready;
   logic             PCWrite;
   logic             IFID_Write;
   logic             IFID_Flush;
   logic             IDEX_Write;
   logic             IDEX_Flush;
   logic             EXMEM_Write;
   logic             MEMWB_Bubble;
   logic             mem_timeout_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ID_opcode, ID_ReadRegNum1, ID_ReadRegNum2,
      output EX_cntl_MemRead, EX_WriteRegNum, EX_BranchTaken,
      output MEM_cntl_MemRead, MEM_cntl_MemWrite, dmem_ready,
      input  PCWrite, IFID_Write, IFID_Flush,
      input  IDEX_Write, IDEX_Flush, EXMEM_Write,
      input  MEMWB_Bubble, mem_timeout_err,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  ID_opcode, ID_ReadRegNum1, ID_ReadRegNum2,
      input  EX_cntl_MemRead, EX_WriteRegNum, EX_BranchTaken,
      input  MEM_cntl_MemRead, MEM_cntl_MemWrite, dmem_ready,
      output PCWrite, IFID_Write, IFID_Flush,
      output IDEX_Write, IDEX_Flush, EXMEM_Write,
      output MEMWB_Bubble, mem_timeout_err,
      output stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for load-use, taken branches and slow
// data-memory accesses, with a MEM timeout and perf counters.
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               reset_n,
   hazard_stall_unit_if.slave hz
);
   localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   state_t           state;
   state_t           nextState;
   logic [WCW-1:0]   waitCnt;
   logic             errFlag;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   logic useRs1;
   logic useRs2;
   logic loadUse;
   logic memBusy;
   logic frozen;
   logic busyAct;
   logic brAct;
   logic luAct;

   always_comb begin
      useRs1 = 1'b1;
      useRs2 = 1'b0;
      unique case (hz.ID_opcode)
         7'b0110111,
         7'b0010111,
         7'b1101111: useRs1 = 1'b0;
         7'b0110011,
         7'b0100011,
         7'b1100011: useRs2 = 1'b1;
         default: ;
      endcase
   end

   assign loadUse = hz.EX_cntl_MemRead
                 && (hz.EX_WriteRegNum != 5'd0)
                 && ((useRs1 && hz.ID_ReadRegNum1 == hz.EX_WriteRegNum)
                  || (useRs2 && hz.ID_ReadRegNum2 == hz.EX_WriteRegNum));

   assign memBusy = (hz.MEM_cntl_MemRead || hz.MEM_cntl_MemWrite)
                 && !hz.dmem_ready;

   // Mutually exclusive activations encode the priority order
   assign frozen  = (state == ERROR);
   assign busyAct = !frozen && memBusy;
   assign brAct   = !frozen && !memBusy && hz.EX_BranchTaken;
   assign luAct   = !frozen && !memBusy && !hz.EX_BranchTaken && loadUse;

   always_comb begin
      nextState = state;
      unique case (state)
         RUN:
            if (memBusy) nextState = MEM_WAIT;
         MEM_WAIT:
            if (!memBusy)                  nextState = RUN;
            else if (waitCnt == WAIT_LAST) nextState = ERROR;
         ERROR:
            nextState = ERROR;
         default:
            nextState = RUN;
      endcase
   end

   always_comb begin
      hz.PCWrite      = 1'b1;
      hz.IFID_Write   = 1'b1;
      hz.IFID_Flush   = 1'b0;
      hz.IDEX_Write   = 1'b1;
      hz.IDEX_Flush   = 1'b0;
      hz.EXMEM_Write  = 1'b1;
      hz.MEMWB_Bubble = 1'b0;
      unique case (1'b1)
         frozen: begin
            hz.PCWrite     = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.IDEX_Write  = 1'b0;
            hz.EXMEM_Write = 1'b0;
         end
         busyAct: begin
            hz.PCWrite      = 1'b0;
            hz.IFID_Write   = 1'b0;
            hz.IDEX_Write   = 1'b0;
            hz.EXMEM_Write  = 1'b0;
            hz.MEMWB_Bubble = 1'b1;
         end
         brAct: begin
            hz.IFID_Flush = 1'b1;
            hz.IDEX_Flush = 1'b1;
         end
         luAct: begin
            hz.PCWrite    = 1'b0;
            hz.IFID_Write = 1'b0;
            hz.IDEX_Flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waitCnt <= '0;
      end else if (state == RUN && nextState == MEM_WAIT) begin
         waitCnt <= '0;
      end else if (state == MEM_WAIT && nextState == MEM_WAIT) begin
         waitCnt <= waitCnt + WCW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         errFlag <= 1'b0;
      end else if (nextState == ERROR) begin
         errFlag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if ((busyAct || luAct) && stallCnt != '1)
            stallCnt <= stallCnt + CNT_W'(1);
         if (brAct && flushCnt != '1)
            flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   assign hz.mem_timeout_err = errFlag;
   assign hz.stall_cycles    = stallCnt;
   assign hz.flush_count     = flushCnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; expected responses
// are queued by the stimulus and checked by a monitor.
module tb_hazard_stall_unit;
   localparam int CW = 4;

   // {PCWrite,IFID_Write,IFID_Flush,IDEX_Write,IDEX_Flush,EXMEM_Write,MEMWB_Bubble}
   localparam logic [6:0] NORM = 7'b1101010;
   localparam logic [6:0] LU   = 7'b0001110;
   localparam logic [6:0] BR   = 7'b1111110;
   localparam logic [6:0] BUSY = 7'b0000001;
   localparam logic [6:0] FRZ  = 7'b0000000;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   typedef struct {
      string         name;
      logic [6:0]    ctl;
      logic          err;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   logic clk;
   logic reset_n;
   exp_t expQ[$];
   int   total;
   int   bad;

   hazard_stall_unit_if #(.CNT_W(CW)) hzIf();

   hazard_stall_unit #(
      .MEM_TIMEOUT(4),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .hz(hzIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         exp_t e;
         logic [6:0] got;
         e = expQ.pop_front();
         got = {hzIf.PCWrite, hzIf.IFID_Write, hzIf.IFID_Flush,
                hzIf.IDEX_Write, hzIf.IDEX_Flush, hzIf.EXMEM_Write,
                hzIf.MEMWB_Bubble};
         total++;
         if (got !== e.ctl || hzIf.mem_timeout_err !== e.err
             || hzIf.stall_cycles !== e.stall
             || hzIf.flush_count !== e.flush) begin
            bad++;
            $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d need ctl=%b err=%b stall=%0d flush=%0d",
                     e.name, got, hzIf.mem_timeout_err, hzIf.stall_cycles,
                     hzIf.flush_count, e.ctl, e.err, e.stall, e.flush);
         end
      end
   end

   task automatic drive(input logic [6:0] opc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic exMr,
                        input logic [4:0] rd, input logic br,
                        input logic mr, input logic mw, input logic rdy);
      hzIf.ID_opcode         = opc;
      hzIf.ID_ReadRegNum1    = rs1;
      hzIf.ID_ReadRegNum2    = rs2;
      hzIf.EX_cntl_MemRead   = exMr;
      hzIf.EX_WriteRegNum    = rd;
      hzIf.EX_BranchTaken    = br;
      hzIf.MEM_cntl_MemRead  = mr;
      hzIf.MEM_cntl_MemWrite = mw;
      hzIf.dmem_ready        = rdy;
   endtask

   task automatic pushExp(input string name, input logic [6:0] ctl,
                          input logic err, input int s, input int f);
      exp_t e;
      e.name  = name;
      e.ctl   = ctl;
      e.err   = err;
      e.stall = CW'(s);
      e.flush = CW'(f);
      expQ.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic luIn();
      drive(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic busyIn();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic pulseReset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset_n = 1'b0;
      idle();
      nextCycle();
      pushExp("reset", NORM, 1'b0, 0, 0);
      nextCycle();
      reset_n = 1'b1;

      luIn();
      pushExp("lu_rs2", LU, 1'b0, 0, 0);
      nextCycle();
      idle();
      pushExp("after_lu", NORM, 1'b0, 1, 0);
      nextCycle();
      drive(OP_LUI, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExp("lui_no_rs", NORM, 1'b0, 1, 0);
      nextCycle();
      drive(OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExp("rd_zero", NORM, 1'b0, 1, 0);
      nextCycle();
      drive(OP_LD, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExp("lu_rs1", LU, 1'b0, 1, 0);
      nextCycle();
      drive(OP_I, 5'd2, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExp("itype_rs2", NORM, 1'b0, 2, 0);
      nextCycle();
      drive(OP_ST, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExp("store_rs2", LU, 1'b0, 2, 0);
      nextCycle();
      drive(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      pushExp("br_over_lu", BR, 1'b0, 3, 0);
      nextCycle();
      idle();
      pushExp("after_br", NORM, 1'b0, 3, 1);
      nextCycle();

      busyIn();
      pushExp("mw1", BUSY, 1'b0, 3, 1);
      nextCycle();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      pushExp("mw2_br_defer", BUSY, 1'b0, 4, 1);
      nextCycle();
      drive(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExp("mw3_lu_defer", BUSY, 1'b0, 5, 1);
      nextCycle();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      pushExp("mw_ready", NORM, 1'b0, 6, 1);
      nextCycle();
      idle();
      pushExp("mw_done", NORM, 1'b0, 6, 1);
      nextCycle();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      pushExp("st_wait", BUSY, 1'b0, 6, 1);
      nextCycle();
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushExp("st_drop", NORM, 1'b0, 7, 1);
      nextCycle();

      pulseReset();
      idle();
      pushExp("rst_clear", NORM, 1'b0, 0, 0);
      nextCycle();
      for (int i = 0; i < 5; i++) begin
         busyIn();
         pushExp($sformatf("tmo_busy%0d", i), BUSY, 1'b0, i, 0);
         nextCycle();
      end
      drive(OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      pushExp("tmo_err_rdy", FRZ, 1'b1, 5, 0);
      nextCycle();
      drive(OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      pushExp("tmo_err_br", FRZ, 1'b1, 5, 0);
      nextCycle();
      pulseReset();
      idle();
      pushExp("err_cleared", NORM, 1'b0, 0, 0);
      nextCycle();

      for (int i = 0; i < 20; i++) begin
         luIn();
         pushExp($sformatf("sat%0d", i), LU, 1'b0, (i > 15) ? 15 : i, 0);
         nextCycle();
      end
      idle();
      pushExp("sat_hold", NORM, 1'b0, 15, 0);
      nextCycle();

      pulseReset();
      busyIn();
      pushExp("ar_busy0", BUSY, 1'b0, 0, 0);
      nextCycle();
      pushExp("ar_busy1", BUSY, 1'b0, 1, 0);
      nextCycle();
      #2;
      reset_n = 1'b0;
      pushExp("ar_midcycle", BUSY, 1'b0, 0, 0);
      nextCycle();
      reset_n = 1'b1;
      idle();
      pushExp("ar_run", NORM, 1'b0, 0, 0);
      nextCycle();
      busyIn();
      pushExp("ar_rebusy", BUSY, 1'b0, 0, 0);
      nextCycle();
      idle();
      pushExp("ar_count", NORM, 1'b0, 1, 0);
      nextCycle();

      @(negedge clk);
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending need 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
